button_cmd_gen: RTL and testbench



---
 rtl/button_cmd_gen.sv | 69 ++++++
 tb/tb_button_cmd_gen.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/button_cmd_gen.sv
// button_cmd_gen: syncs and debounces two raw buttons into start/stop/reset command pulses.
// Optional LONG_PRESS_RESET_EN: holding btn_ss for LONG_CYCLES also issues one reset.
module button_cmd_gen #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int LONG_CYCLES     = 200_000_000,
   parameter bit BTN_ACTIVE_HIGH = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_ss,
   input  logic       btn_rst,
   input  logic [1:0] state,
   output logic       start,
   output logic       stop,
   output logic       reset,
   output logic       btn_ss_level
);
   localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   // bit 0 is btn_ss, bit 1 is btn_rst
   logic [1:0]    raw, s1, s2, lvl, lvl_q, press;
   logic [DW-1:0] cnt [2];
   logic          long_p, any_rst;
   assign raw = BTN_ACTIVE_HIGH ? {btn_rst, btn_ss} : ~{btn_rst, btn_ss};
   always_ff @(posedge clk) begin
      if (rst) begin
         s1    <= '0;
         s2    <= '0;
         lvl   <= '0;
         lvl_q <= '0;
         press <= '0;
         for (int i = 0; i < 2; i++) cnt[i] <= '0;
      end else begin
         s1    <= raw;
         s2    <= s1;
         lvl_q <= lvl;
         press <= lvl & ~lvl_q;
         for (int i = 0; i < 2; i++) begin
            if (s2[i] == lvl[i]) cnt[i] <= '0;
            else if (cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
               lvl[i] <= ~lvl[i];
               cnt[i] <= '0;
            end else cnt[i] <= cnt[i] + 1'b1;
         end
      end
   end
`ifdef LONG_PRESS_RESET_EN
   localparam int LW = $clog2(LONG_CYCLES + 1);
   logic [LW-1:0] hold;
   // hold saturates at LONG_CYCLES so the long-press reset fires once per hold
   always_ff @(posedge clk) begin
      if (rst) begin
         hold   <= '0;
         long_p <= 1'b0;
      end else begin
         hold   <= !lvl[0] ? '0 : (hold == LW'(LONG_CYCLES)) ? hold : hold + 1'b1;
         long_p <= lvl[0] && (hold == LW'(LONG_CYCLES - 1));
      end
   end
`else
   assign long_p = 1'b0;
`endif
   always_comb begin
      any_rst      = press[1] | long_p;
      reset        = any_rst;
      start        = press[0] && !any_rst && (state == 2'b00 || state == 2'b10);
      stop         = press[0] && !any_rst && (state == 2'b01);
      btn_ss_level = lvl[0];
   end
endmodule

// File: tb/tb_button_cmd_gen.sv
// tb_button_cmd_gen: randomized and directed checks of button_cmd_gen against a cycle-history model.
// Honours LONG_PRESS_RESET_EN the same way as the design.
module tb_button_cmd_gen;
   localparam int D = 4;
   localparam int L = 20;
   localparam int MAXC = 2000;
   logic clk = 1'b0, rst = 1'b1, btn_ss = 1'b0, btn_rst = 1'b0;
   logic [1:0] state = 2'b00;
   logic start, stop, reset, btn_ss_level;
   int vectors = 0, errors = 0, t = 0;
   logic raw_h [2][MAXC];
   logic lvl_h [2][MAXC];
   logic [3:0] got, exp_v;

   button_cmd_gen #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .BTN_ACTIVE_HIGH(1'b1)) dut (
      .clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_rst(btn_rst), .state(state),
      .start(start), .stop(stop), .reset(reset), .btn_ss_level(btn_ss_level)
   );

   always #5 clk = ~clk;

   function automatic logic lv(input int b, input int k);
      return (k < 0) ? 1'b0 : lvl_h[b][k];
   endfunction

   function automatic logic sy(input int b, input int k);
      return (k < 2) ? 1'b0 : raw_h[b][k-2];
   endfunction

   // level flips once the synced input has disagreed with it for D straight cycles
   function automatic logic next_level(input int b, input int c);
      logic prev = lv(b, c - 1);
      logic flip = 1'b1;
      for (int j = c - D; j < c; j++) if (j < 0 || sy(b, j) == prev) flip = 1'b0;
      return flip ? ~prev : prev;
   endfunction

   function automatic logic long_hit(input int c);
      logic h = 1'b0;
`ifdef LONG_PRESS_RESET_EN
      h = (c >= L) && !lv(0, c - L - 1);
      for (int j = c - L; j < c; j++) if (!lv(0, j)) h = 1'b0;
`endif
      return h;
   endfunction

   task automatic cyc(input logic ss, input logic rb, input logic [1:0] st);
      logic ps, pr, rs;
      btn_ss = ss; btn_rst = rb; state = st;
      raw_h[0][t] = ss; raw_h[1][t] = rb;
      lvl_h[0][t] = next_level(0, t);
      lvl_h[1][t] = next_level(1, t);
      ps = lv(0, t - 1) && !lv(0, t - 2);
      pr = lv(1, t - 1) && !lv(1, t - 2);
      rs = pr || long_hit(t);
      exp_v = {ps && !rs && (st == 2'b00 || st == 2'b10), ps && !rs && st == 2'b01, rs, lv(0, t)};
      #1;
      got = {start, stop, reset, btn_ss_level};
      vectors++;
      if (got !== exp_v) begin
         errors++;
         $display("FAIL cycle %0d {start,stop,reset,level}: got %b expected %b", t, got, exp_v);
      end
      @(posedge clk); #1;
      t++;
   endtask

   task automatic test_reset();
      rst = 1'b1; btn_ss = 1'b0; btn_rst = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         vectors++;
         if ({start, stop, reset, btn_ss_level} !== 4'b0000) begin
            errors++;
            $display("FAIL reset outputs: got %b expected 0000", {start, stop, reset, btn_ss_level});
         end
      end
      rst = 1'b0;
      t = 0;
   endtask

   task automatic test_start();
      int first = -1, n = 0;
      test_reset();
      for (int i = 0; i < 14; i++) begin
         cyc(1'b1, 1'b0, 2'b00);
         if (got[3]) begin n++; if (first < 0) first = i; end
      end
      vectors++;
      if (first != 7 || n != 1) begin
         errors++;
         $display("FAIL start_latency: got cycle %0d count %0d expected cycle 7 count 1", first, n);
      end
   endtask

   task automatic test_stop_then_start();
      int ns = 0, nt = 0;
      test_reset();
      for (int i = 0; i < 12; i++) begin cyc(1'b1, 1'b0, 2'b01); if (got[2]) ns++; end
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 2'b10);
      for (int i = 0; i < 12; i++) begin cyc(1'b1, 1'b0, 2'b10); if (got[3]) nt++; end
      vectors++;
      if (ns != 1 || nt != 1) begin
         errors++;
         $display("FAIL stop_then_start: got stop %0d start %0d expected 1 1", ns, nt);
      end
   endtask

   task automatic test_bounce();
      int n = 0;
      test_reset();
      for (int i = 0; i < 8; i++) begin cyc(i[1] == 1'b0, 1'b0, 2'b00); if (got != 4'b0) n++; end
      for (int i = 0; i < 10; i++) begin cyc(1'b0, 1'b0, 2'b00); if (got != 4'b0) n++; end
      vectors++;
      if (n != 0) begin
         errors++;
         $display("FAIL bounce: got %0d active cycles expected 0", n);
      end
   endtask

   task automatic test_both();
      int nr = 0, nss = 0;
      test_reset();
      for (int i = 0; i < 12; i++) begin
         cyc(1'b1, 1'b1, 2'b00);
         if (got[1]) nr++;
         if (got[3] || got[2]) nss++;
      end
      vectors++;
      if (nr != 1 || nss != 0) begin
         errors++;
         $display("FAIL both_pressed: got reset %0d start/stop %0d expected 1 0", nr, nss);
      end
   endtask

   task automatic test_long();
      int nr = 0, rc = -1, ns = 0, exp_nr;
      test_reset();
      for (int i = 0; i < 40; i++) begin
         cyc(1'b1, 1'b0, 2'b00);
         if (got[1]) begin nr++; rc = i; end
         if (got[3]) ns++;
      end
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 2'b00);
`ifdef LONG_PRESS_RESET_EN
      exp_nr = 1;
`else
      exp_nr = 0;
`endif
      vectors++;
      if (nr != exp_nr || ns != 1 || (exp_nr == 1 && rc != 26)) begin
         errors++;
         $display("FAIL long_hold: got reset %0d at %0d start %0d expected reset %0d start 1", nr, rc, ns, exp_nr);
      end
   endtask

   task automatic test_random();
      logic ss = 1'b0, rb = 1'b0;
      int run_s = 0, run_r = 0;
      test_reset();
      for (int i = 0; i < 600; i++) begin
         if (run_s == 0) begin ss = $urandom_range(0, 1); run_s = $urandom_range(1, 9); end
         if (run_r == 0) begin rb = $urandom_range(0, 1); run_r = $urandom_range(1, 12); end
         run_s--; run_r--;
         cyc(ss, rb, 2'($urandom_range(0, 3)));
      end
   endtask

   initial begin
      test_reset();
      test_start();
      test_stop_then_start();
      test_bounce();
      test_both();
      test_long();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
